// File: rtl/chan_en_sequencer.sv
// Staggered channel-enable sequencer for the cochlea filterbank comparators
// and level shifters. Switches one channel per step with a programmable
// dwell between steps to limit inrush on vccd1.
// Optional build macro: CHSEQ_TIE_HIGH_EN -- reset into ALL_ON with every
// channel enabled, mimicking the former tie-high enables.
module chan_en_sequencer #(
   parameter int N_CH    = 16,
   parameter int DWELL_W = 8
) (
`ifdef USE_POWER_PINS
   inout  wire                     vccd1,
   inout  wire                     vssd1,
`endif
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    target_on,
   input  logic [DWELL_W-1:0]      dwell,
   input  logic [N_CH-1:0]         ch_mask,
   output logic [N_CH-1:0]         ch_en,
   output logic                    busy,
   output logic                    done,
   output logic [$clog2(N_CH)-1:0] cur_ch
);

   localparam int IW = $clog2(N_CH);
   localparam logic [IW-1:0] LAST = IW'(N_CH - 1);

   typedef enum logic [1:0] {
      ST_OFF,
      ST_RAMP_UP,
      ST_ALL_ON,
      ST_RAMP_DOWN
   } state_t;

   state_t             state;
   logic [IW-1:0]      idx;
   logic [DWELL_W-1:0] cnt;
   logic               hit;
   logic               step_adv;

   // cnt==0 means the channel at idx has not been processed yet; a non-zero
   // cnt means it was switched and we are dwelling on it. The index advances
   // on the edge where the dwell expires, or on the processing edge itself
   // when no dwell is owed (skipped channel or dwell==0).
   always_comb begin
      hit      = (state == ST_RAMP_UP) ? ch_mask[idx] : ch_en[idx];
      step_adv = (cnt == DWELL_W'(1)) || ((cnt == '0) && (!hit || (dwell == '0)));
   end

   // Sequencer FSM with registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
`ifdef CHSEQ_TIE_HIGH_EN
         state <= ST_ALL_ON;
         ch_en <= '1;
`else
         state <= ST_OFF;
         ch_en <= '0;
`endif
         busy   <= 1'b0;
         done   <= 1'b0;
         cur_ch <= '0;
         idx    <= '0;
         cnt    <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_OFF: begin
               if (target_on) begin
                  state <= ST_RAMP_UP;
                  idx   <= '0;
                  cnt   <= '0;
                  busy  <= 1'b1;
               end
            end
            ST_ALL_ON: begin
               if (!target_on) begin
                  state <= ST_RAMP_DOWN;
                  idx   <= LAST;
                  cnt   <= '0;
                  busy  <= 1'b1;
               end
            end
            ST_RAMP_UP: begin
               if (!target_on) begin
                  // reverse at the current index, dropping any remaining dwell
                  state <= ST_RAMP_DOWN;
                  cnt   <= '0;
               end else begin
                  if (cnt != '0) begin
                     cnt <= cnt - 1'b1;
                  end else begin
                     cur_ch <= idx;
                     if (ch_mask[idx]) begin
                        ch_en[idx] <= 1'b1;
                        cnt        <= dwell;
                     end
                  end
                  if (step_adv) begin
                     if (idx == LAST) begin
                        state <= ST_ALL_ON;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                     end else begin
                        idx <= idx + 1'b1;
                     end
                  end
               end
            end
            ST_RAMP_DOWN: begin
               if (target_on) begin
                  state <= ST_RAMP_UP;
                  cnt   <= '0;
               end else begin
                  if (cnt != '0) begin
                     cnt <= cnt - 1'b1;
                  end else begin
                     cur_ch <= idx;
                     if (ch_en[idx]) begin
                        ch_en[idx] <= 1'b0;
                        cnt        <= dwell;
                     end
                  end
                  if (step_adv) begin
                     if (idx == '0) begin
                        state <= ST_OFF;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                     end else begin
                        idx <= idx - 1'b1;
                     end
                  end
               end
            end
            default: state <= ST_OFF;
         endcase
      end
   end

endmodule

// File: tb/tb_chan_en_sequencer.sv
// Self-checking bench for chan_en_sequencer. Expected behaviour comes from a
// per-ramp schedule: each channel costs one step cycle, plus dwell cycles
// when it actually switches.
module tb_chan_en_sequencer;

   localparam int N  = 16;
   localparam int DW = 8;
`ifdef CHSEQ_TIE_HIGH_EN
   localparam logic [N-1:0] RST_EN  = '1;
   localparam logic         RST_TGT = 1'b1;
`else
   localparam logic [N-1:0] RST_EN  = '0;
   localparam logic         RST_TGT = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          target_on = RST_TGT;
   logic [DW-1:0] dwell = '0;
   logic [N-1:0]  ch_mask = '0;
   logic [N-1:0]  ch_en;
   logic          busy, done;
   logic [3:0]    cur_ch;
`ifdef USE_POWER_PINS
   wire vccd1, vssd1;
`endif

   chan_en_sequencer #(.N_CH(N), .DWELL_W(DW)) dut (
`ifdef USE_POWER_PINS
      .vccd1(vccd1), .vssd1(vssd1),
`endif
      .clk(clk), .rst_n(rst_n), .target_on(target_on), .dwell(dwell),
      .ch_mask(ch_mask), .ch_en(ch_en), .busy(busy), .done(done), .cur_ch(cur_ch)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   logic [N-1:0] m_en;
   logic [N-1:0] q_en[$];
   int           q_idx[$];
   int           q_cur[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic void push(input logic [N-1:0] e, input int ix, input int cu);
      q_en.push_back(e);
      q_idx.push_back(ix);
      q_cur.push_back(cu);
   endfunction

   // One entry per clock edge of the ramp: enables after that edge, the index
   // the ramp would resume from if reversed there, and the channel stepped.
   function automatic void build(input bit up, input int start, input logic [N-1:0] en0,
                                 input logic [N-1:0] mask, input int d);
      logic [N-1:0] en;
      bit hit;
      en = en0;
      q_en.delete(); q_idx.delete(); q_cur.delete();
      if (up) begin
         for (int i = start; i < N; i++) begin
            hit = mask[i];
            if (hit) en[i] = 1'b1;
            push(en, (hit && d > 0) ? i : i + 1, i);
            if (hit) for (int c = 1; c <= d; c++) push(en, (c == d) ? i + 1 : i, i);
         end
      end else begin
         for (int i = start; i >= 0; i--) begin
            hit = en[i];
            en[i] = 1'b0;
            push(en, (hit && d > 0) ? i : i - 1, i);
            if (hit) for (int c = 1; c <= d; c++) push(en, (c == d) ? i - 1 : i, i);
         end
      end
   endfunction

   task automatic enter(input bit up);
      target_on = up;
      @(posedge clk); #1;
      chk("entry_busy", busy, 1);
      chk("entry_done", done, 0);
      chk("entry_en", ch_en, m_en);
   endtask

   task automatic hold(input int cyc);
      for (int i = 0; i < cyc; i++) begin
         @(posedge clk); #1;
         chk("hold_en", ch_en, m_en);
         chk("hold_busy", busy, 0);
         chk("hold_done", done, 0);
      end
   endtask

   task automatic walk(input bit up, input int start, input int d, input logic [N-1:0] mask,
                       input int abort_k, input bit flip, output int nxt, output bit aborted);
      int n, lim;
      dwell   = DW'(d);
      ch_mask = mask;
      build(up, start, m_en, mask, d);
      n       = q_en.size();
      aborted = (abort_k > 0 && abort_k < n);
      lim     = aborted ? abort_k : n;
      for (int e = 0; e < lim; e++) begin
         @(posedge clk); #1;
         chk(up ? "up_en" : "dn_en", ch_en, q_en[e]);
         chk("cur_ch", cur_ch, q_cur[e]);
         chk("done", done, (e == n - 1));
         chk("busy", busy, (e != n - 1));
         m_en = q_en[e];
      end
      nxt = q_idx[lim-1];
      if (aborted && flip) begin
         target_on = !up;
         @(posedge clk); #1;
         chk("rev_en", ch_en, m_en);
         chk("rev_busy", busy, 1);
         chk("rev_done", done, 0);
      end else if (!aborted) begin
         hold(1);
      end
   endtask

   // Leaves the DUT settled in OFF with m_en==0 after a reset release.
   task automatic settle_after_reset();
      int nx; bit ab;
      hold(3);
`ifdef CHSEQ_TIE_HIGH_EN
      ch_mask = '0;  // ignored in ALL_ON: enables must stay all ones
      hold(2);
      enter(0);
      walk(0, N - 1, 1, '0, 0, 0, nx, ab);
`endif
   endtask

   initial begin
      int nx, nx2, k;
      bit ab, ab2, st_on, up;
      logic [N-1:0] mk;
      int d;

      // power-on reset
      #1 rst_n = 1'b0;
      #1;
      chk("rst_en", ch_en, RST_EN);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_cur", cur_ch, 0);
      m_en = RST_EN;
      @(negedge clk); rst_n = 1'b1;
      settle_after_reset();

      // basic up-ramp: dwell 2, all channels, done after 48 cycles
      m_en = '0;
      enter(1);
      walk(1, 0, 2, 16'hFFFF, 0, 0, nx, ab);
      chk("up_final", ch_en, 16'hFFFF);
      ch_mask = 16'h1234;  // ignored in ALL_ON
      hold(3);
      enter(0);
      walk(0, N - 1, 0, 16'h1234, 0, 0, nx, ab);

      // masked up/down with dwell 0
      enter(1);
      walk(1, 0, 0, 16'h00F0, 0, 0, nx, ab);
      chk("mask_final", ch_en, 16'h00F0);
      enter(0);
      walk(0, N - 1, 0, 16'h00F0, 0, 0, nx, ab);
      chk("mask_off", ch_en, 0);

      // mid-ramp reversal while dwelling on channel 5
      enter(1);
      walk(1, 0, 3, 16'hFFFF, 21, 1, nx, ab);
      chk("rev_cur5", cur_ch, 5);
      walk(0, nx, 3, 16'hFFFF, 0, 0, nx2, ab2);
      chk("rev_off", ch_en, 0);

      // async reset mid-ramp with ch_en = 003F
      enter(1);
      walk(1, 0, 0, 16'hFFFF, 6, 0, nx, ab);
      chk("pre_rst_en", ch_en, 16'h003F);
      #3 rst_n = 1'b0;
      #1;
      chk("arst_en", ch_en, RST_EN);
      chk("arst_busy", busy, 0);
      chk("arst_cur", cur_ch, 0);
      m_en = RST_EN;
      target_on = RST_TGT;
      @(negedge clk); rst_n = 1'b1;
      settle_after_reset();

      // max dwell with zero mask, then with only channel 0
      m_en = '0;
      enter(1);
      walk(1, 0, 255, 16'h0000, 0, 0, nx, ab);
      chk("zmask_en", ch_en, 0);
      enter(0);
      walk(0, N - 1, 255, 16'h0000, 0, 0, nx, ab);
      enter(1);
      walk(1, 0, 255, 16'h0001, 0, 0, nx, ab);
      enter(0);
      walk(0, N - 1, 255, 16'h0001, 0, 0, nx, ab);

      // randomized ramps with occasional reversal
      st_on = 1'b0;
      for (int t = 0; t < 24; t++) begin
         mk = N'($urandom);
         d  = ($urandom_range(0, 7) == 0) ? $urandom_range(4, 9) : $urandom_range(0, 3);
         k  = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 40) : 0;
         up = !st_on;
         ch_mask = mk;
         enter(up);
         walk(up, up ? 0 : N - 1, d, mk, k, 1, nx, ab);
         if (ab) begin
            walk(!up, nx, d, mk, 0, 0, nx2, ab2);
            st_on = !up;
         end else begin
            st_on = up;
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
